// File: rtl/vis_pkg.sv
// Shared definitions for the display-path converters: FSM state encoding and BCD sizing.
package vis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_MAX = 9999;
  localparam int NDIG    = 4;
  localparam int BCD_W   = 16;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to any digit >= 5 before the next left shift.
module bcd_add3 (
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = (x >= 4'd5) ? x + 4'd3 : x;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock, saturating at 9999.
//
// state | meaning
// IDLE  | waiting for start; dat/ovf hold the last result
// SHIFT | one double-dabble step per cycle, W_BIN cycles
// DONE  | publish dat/ovf, pulse done, drop busy
module bin2bcd_seq
  import vis_pkg::*;
#(
  parameter int W_BIN = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W_BIN-1:0] bin,
  output logic [15:0]      dat,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int          CW    = $clog2(W_BIN + 1);
  localparam logic [31:0] MAX_V = BCD_MAX;

  state_t             state;
  logic [W_BIN-1:0]   sh;
  logic [W_BIN-1:0]   bin_lat;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj;
  logic [CW-1:0]      cnt;
  logic               sat;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_add3 u_add3 (
      .x (acc[4*g +: 4]),
      .y (acc_adj[4*g +: 4])
    );
  end

  // Saturation looks at the captured value so a changing bin input cannot disturb it.
  assign sat = 32'(bin_lat) > MAX_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      bin_lat <= '0;
      acc     <= '0;
      cnt     <= '0;
      dat     <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh      <= bin;
            bin_lat <= bin;
            acc     <= '0;
            cnt     <= CW'(W_BIN);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Carry out of the top digit is dropped; only reachable when saturating.
          acc <= BCD_W'({acc_adj, sh[W_BIN-1]});
          sh  <= sh << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          ovf   <= sat;
          dat   <= sat ? 16'h9999 : acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
